priv_trap_sequencer: RTL and testbench
======================================

Name: priv_trap_sequencer

Overview:
Parametrised trap/return sequencer for the machine-mode privilege unit. It replaces the hard-coded single-cause control path with NUM_EXC synchronous exception lines and NUM_INTR interrupt lines, and adds fixed priority resolution and vectored mtvec dispatch. It runs a flush/commit handshake with the pipeline controller. It sits between the hazard unit and the CSR file, and produces CSR update strobes plus the redirect PC.

Parameters:
XLEN, 32, data/address width
NUM_EXC, 16, exception request lines; bit index = exception code
NUM_INTR, 16, interrupt lines; bit index = interrupt code; legal range 12..32

Ports:
CLK  input  1  clock
RST  input  1  synchronous active-high reset
exc_req  input  NUM_EXC  exception requests from commit stage, valid one cycle
exc_epc  input  XLEN  PC of faulting instruction
exc_tval  input  XLEN  trap value for exc_req
intr_pending  input  NUM_INTR  mip image
intr_enable  input  NUM_INTR  mie image
mstatus_mie  input  1  global interrupt enable
next_pc  input  XLEN  PC to save on interrupt
mret  input  1  mret retiring
pipe_clear  input  1  pipeline drained
mtvec_base  input  XLEN  mtvec with low 2 bits zeroed
mtvec_mode  input  2  0 direct, 1 vectored, 2/3 treated as direct
mepc_r  input  XLEN  current mepc
trap_req  output  1  flush request to pipeline controller
insert_pc  output  1  redirect strobe
priv_pc  output  XLEN  redirect target
cause_we  output  1  mcause write strobe
cause_next  output  XLEN  {interrupt bit, code}
epc_we  output  1  mepc write strobe
epc_next  output  XLEN  value written to mepc
tval_we  output  1  mtval write strobe
tval_next  output  XLEN  value written to mtval
mstatus_trap_we  output  1  MPIE<=MIE, MIE<=0
mstatus_ret_we  output  1  MIE<=MPIE, MPIE<=1
busy  output  1  FSM not in IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched cause/epc/tval/target cleared.
- States: IDLE, TRAP_FLUSH, TRAP_COMMIT, RET_FLUSH, RET_COMMIT.
- IDLE arbitration, evaluated every cycle:
  - Any exc_req bit set → exception wins.
  - Else any (intr_pending & intr_enable) bit with mstatus_mie=1 → interrupt.
  - Else mret → return.
  - Exception beats mret when both occur in the same cycle.
- Exception priority: code 3 (breakpoint) first, then lowest set index. cause_next = {0, code}; epc = exc_epc; tval = exc_tval.
- Interrupt priority: 11, 3, 7, then remaining enabled bits, highest index first. cause_next = {1, code}; epc = next_pc; tval = 0.
- Everything is latched on acceptance; later input changes are ignored until the FSM returns to IDLE.
- TRAP_FLUSH:
  - trap_req=1.
  - Stay until pipe_clear=1 is sampled, then go to TRAP_COMMIT.
  - Minimum latency: request cycle N, TRAP_FLUSH at N+1, TRAP_COMMIT at N+2.
- TRAP_COMMIT (exactly one cycle):
  - insert_pc, cause_we, epc_we, tval_we and mstatus_trap_we all =1.
  - priv_pc = mtvec_base + 4*code when vectored and interrupt; otherwise mtvec_base.
  - The add wraps modulo 2^XLEN.
  - Next state IDLE.
- RET_FLUSH: trap_req=1; wait for pipe_clear. RET_COMMIT (one cycle): insert_pc=1, mstatus_ret_we=1, priv_pc = mepc_r sampled in this cycle; then IDLE.
- IDLE never accepts a new event in the same cycle COMMIT exits. The first new acceptance is in the cycle after returning to IDLE.
- Events while busy are not queued: exc_req and mret are dropped; interrupts persist via level-sensitive mip.
- RST asserted in any state forces IDLE and drops all strobes the same cycle. No partial CSR write may occur.
- Bits of exc_req at index ≥16 use the same lowest-index rule.

Optional Feature:
PRIV_NMI_EN
- Enabled: adds input nmi (1, level), parameter NMI_VECTOR (default 32'h0000_0100) and parameter NMI_CAUSE (default 0).
  - nmi beats exceptions and interrupts, and ignores mstatus_mie.
  - cause_next = {1, NMI_CAUSE}; priv_pc = NMI_VECTOR regardless of mtvec_mode.
  - mstatus_trap_we is still asserted.
- Disabled: port and parameters absent; behaviour exactly as above.

Decomposition:
- Package priv_trap_pkg holds:
  - trap_state_t enum.
  - mtvec_mode_t enum (DIRECT, VECTORED).
  - Interrupt code constants (MSI=3, MTI=7, MEI=11) and BREAKPOINT=3.
  - cause_t struct {logic intr; logic [XLEN-2:0] code}.
- Sub-module priv_trap_prio_enc: combinational. Takes masked exception and interrupt vectors; returns valid, is_intr and code.

Test Plan:
- exc_req=16'h000C (codes 2 and 3), exc_epc=0x400, tval=0xDEAD, pipe_clear two cycles later → trap_req held for 2 cycles, then one-cycle commit with cause_next=0x3, epc_next=0x400, tval_next=0xDEAD, priv_pc=mtvec_base.
- mtvec_base=0x8000, mode=1, mstatus_mie=1, pending=enable=(1<<7)|(1<<11) → cause_next=0x8000000B, priv_pc=0x802C, tval_next=0.
- mstatus_mie=0 with pending=enable=0x80 → no trap_req; then mret=1 with mepc_r=0x1234 → RET_COMMIT with priv_pc=0x1234 and mstatus_ret_we=1.
- exc_req[2] and mret in the same cycle → trap path taken; mstatus_ret_we never asserted.
- RST pulsed during TRAP_FLUSH → all outputs 0 the same cycle; no cause_we afterwards.
- PRIV_NMI_EN: nmi=1 with exc_req[2] → priv_pc=0x100, cause_next=0x80000000.

Source files
------------

// File: rtl/priv_trap_pkg.sv
// priv_trap_pkg: shared types and constants for the machine-mode trap sequencer.
package priv_trap_pkg;
  localparam int CAUSE_W = 32;
  localparam int CODE_W = 8;
  localparam int MSI = 3;
  localparam int MTI = 7;
  localparam int MEI = 11;
  localparam int BREAKPOINT = 3;
  typedef enum logic [2:0] {IDLE, TRAP_FLUSH, TRAP_COMMIT, RET_FLUSH, RET_COMMIT} trap_state_t;
  typedef enum logic [1:0] {DIRECT = 2'd0, VECTORED = 2'd1} mtvec_mode_t;
  typedef struct packed {
    logic intr;
    logic [CAUSE_W-2:0] code;
  } cause_t;
endpackage

// File: rtl/priv_trap_prio_enc.sv
// priv_trap_prio_enc: fixed-priority resolution of exception and masked interrupt lines.
module priv_trap_prio_enc import priv_trap_pkg::*; #(
  parameter int NUM_EXC = 16,
  parameter int NUM_INTR = 16
) (
  input  logic [NUM_EXC-1:0]  exc_i,
  input  logic [NUM_INTR-1:0] intr_i,
  output logic                valid_o,
  output logic                is_intr_o,
  output logic [CODE_W-1:0]   code_o
);
  logic [CODE_W-1:0] exc_code, intr_code;
  // Later assignments win: descending scan leaves the lowest index, breakpoint overrides.
  always_comb begin
    exc_code = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) if (exc_i[i]) exc_code = CODE_W'(i);
    if (exc_i[BREAKPOINT]) exc_code = CODE_W'(BREAKPOINT);
  end
  // Ascending scan leaves the highest index; the named sources then override in rising priority.
  always_comb begin
    intr_code = '0;
    for (int i = 0; i < NUM_INTR; i++) if (intr_i[i]) intr_code = CODE_W'(i);
    if (intr_i[MTI]) intr_code = CODE_W'(MTI);
    if (intr_i[MSI]) intr_code = CODE_W'(MSI);
    if (intr_i[MEI]) intr_code = CODE_W'(MEI);
  end
  assign valid_o = |exc_i || |intr_i;
  assign is_intr_o = ~|exc_i;
  assign code_o = |exc_i ? exc_code : intr_code;
endmodule

// File: rtl/priv_trap_sequencer.sv
// priv_trap_sequencer: trap/mret flush-commit sequencer with priority and vectored dispatch.
// Optional non-maskable interrupt input enabled by PRIV_NMI_EN.
module priv_trap_sequencer import priv_trap_pkg::*; #(
  parameter int XLEN = 32,
  parameter int NUM_EXC = 16,
  parameter int NUM_INTR = 16
`ifdef PRIV_NMI_EN
  , parameter logic [XLEN-1:0] NMI_VECTOR = 32'h0000_0100
  , parameter int NMI_CAUSE = 0
`endif
) (
  input  logic                CLK,
  input  logic                RST,
`ifdef PRIV_NMI_EN
  input  logic                nmi,
`endif
  input  logic [NUM_EXC-1:0]  exc_req,
  input  logic [XLEN-1:0]     exc_epc,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic [NUM_INTR-1:0] intr_pending,
  input  logic [NUM_INTR-1:0] intr_enable,
  input  logic                mstatus_mie,
  input  logic [XLEN-1:0]     next_pc,
  input  logic                mret,
  input  logic                pipe_clear,
  input  logic [XLEN-1:0]     mtvec_base,
  input  logic [1:0]          mtvec_mode,
  input  logic [XLEN-1:0]     mepc_r,
  output logic                trap_req,
  output logic                insert_pc,
  output logic [XLEN-1:0]     priv_pc,
  output logic                cause_we,
  output logic [XLEN-1:0]     cause_next,
  output logic                epc_we,
  output logic [XLEN-1:0]     epc_next,
  output logic                tval_we,
  output logic [XLEN-1:0]     tval_next,
  output logic                mstatus_trap_we,
  output logic                mstatus_ret_we,
  output logic                busy
);
  trap_state_t state_q, state_d;
  cause_t cause_q;
  logic [XLEN-1:0] epc_q, tval_q, tgt_q;
  logic enc_valid, enc_intr, nmi_act, trap_v, ret_v, t_intr, live;
  logic [CODE_W-1:0] enc_code, nmi_code, t_code;
  logic [XLEN-1:0] nmi_vec, vec_pc, t_pc;
`ifdef PRIV_NMI_EN
  assign nmi_act = nmi;
  assign nmi_code = CODE_W'(NMI_CAUSE);
  assign nmi_vec = NMI_VECTOR;
`else
  assign nmi_act = 1'b0;
  assign nmi_code = '0;
  assign nmi_vec = '0;
`endif
  priv_trap_prio_enc #(.NUM_EXC(NUM_EXC), .NUM_INTR(NUM_INTR)) u_enc (
    .exc_i     (exc_req),
    .intr_i    (intr_pending & intr_enable & {NUM_INTR{mstatus_mie}}),
    .valid_o   (enc_valid),
    .is_intr_o (enc_intr),
    .code_o    (enc_code)
  );
  always_comb begin
    trap_v = nmi_act | enc_valid;
    ret_v = mret & ~trap_v;
    t_intr = nmi_act | enc_intr;
    t_code = nmi_act ? nmi_code : enc_code;
    vec_pc = mtvec_base + (XLEN'(enc_code) << 2);
    t_pc = nmi_act ? nmi_vec : (enc_intr && mtvec_mode_t'(mtvec_mode) == VECTORED) ? vec_pc : mtvec_base;
  end
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cause_q <= '0;
      epc_q <= '0;
      tval_q <= '0;
      tgt_q <= '0;
    end else if (state_q == IDLE && trap_v) begin
      cause_q <= '{intr: t_intr, code: (CAUSE_W-1)'(t_code)};
      epc_q <= t_intr ? next_pc : exc_epc;
      tval_q <= t_intr ? '0 : exc_tval;
      tgt_q <= t_pc;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        state_d = trap_v ? TRAP_FLUSH : ret_v ? RET_FLUSH : IDLE;
      TRAP_FLUSH:  state_d = pipe_clear ? TRAP_COMMIT : TRAP_FLUSH;
      RET_FLUSH:   state_d = pipe_clear ? RET_COMMIT : RET_FLUSH;
      default:     state_d = IDLE;
    endcase
  end
  // Outputs are gated by RST directly so a reset mid-sequence kills strobes in the same cycle.
  always_comb begin
    live = ~RST;
    trap_req = live && (state_q == TRAP_FLUSH || state_q == RET_FLUSH);
    insert_pc = live && (state_q == TRAP_COMMIT || state_q == RET_COMMIT);
    cause_we = live && state_q == TRAP_COMMIT;
    epc_we = cause_we;
    tval_we = cause_we;
    mstatus_trap_we = cause_we;
    mstatus_ret_we = live && state_q == RET_COMMIT;
    busy = live && state_q != IDLE;
    priv_pc = cause_we ? tgt_q : mstatus_ret_we ? mepc_r : '0;
    cause_next = live ? {cause_q.intr, (XLEN-1)'(cause_q.code)} : '0;
    epc_next = live ? epc_q : '0;
    tval_next = live ? tval_q : '0;
  end
endmodule

// File: tb/tb_priv_trap_sequencer.sv
// tb_priv_trap_sequencer: directed scoreboard bench for priv_trap_sequencer.
module tb_priv_trap_sequencer;
  logic CLK = 0, RST = 1;
`ifdef PRIV_NMI_EN
  logic nmi = 0;
`endif
  logic [15:0] exc_req = 0, intr_pending = 0, intr_enable = 0;
  logic [31:0] exc_epc = 0, exc_tval = 0, next_pc = 0, mtvec_base = 0, mepc_r = 0;
  logic mstatus_mie = 0, mret = 0, pipe_clear = 0;
  logic [1:0] mtvec_mode = 0;
  logic trap_req, insert_pc, cause_we, epc_we, tval_we, mstatus_trap_we, mstatus_ret_we, busy;
  logic [31:0] priv_pc, cause_next, epc_next, tval_next;
  typedef struct {logic ret; logic [31:0] pc, cause, epc, tval;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0, pushed = 0, seen = 0;

  priv_trap_sequencer dut (
    .CLK(CLK), .RST(RST),
`ifdef PRIV_NMI_EN
    .nmi(nmi),
`endif
    .exc_req(exc_req), .exc_epc(exc_epc), .exc_tval(exc_tval),
    .intr_pending(intr_pending), .intr_enable(intr_enable), .mstatus_mie(mstatus_mie),
    .next_pc(next_pc), .mret(mret), .pipe_clear(pipe_clear),
    .mtvec_base(mtvec_base), .mtvec_mode(mtvec_mode), .mepc_r(mepc_r),
    .trap_req(trap_req), .insert_pc(insert_pc), .priv_pc(priv_pc),
    .cause_we(cause_we), .cause_next(cause_next), .epc_we(epc_we), .epc_next(epc_next),
    .tval_we(tval_we), .tval_next(tval_next), .mstatus_trap_we(mstatus_trap_we),
    .mstatus_ret_we(mstatus_ret_we), .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string n, logic [31:0] a, logic [31:0] b);
    checks++;
    if (a !== b) begin
      failures++;
      $display("FAIL %s got=%h required=%h", n, a, b);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_trap(logic [31:0] pc, logic [31:0] cause, logic [31:0] epc, logic [31:0] tval);
    q.push_back('{ret: 1'b0, pc: pc, cause: cause, epc: epc, tval: tval});
    pushed++;
  endtask

  task automatic expect_ret(logic [31:0] pc);
    q.push_back('{ret: 1'b1, pc: pc, cause: 0, epc: 0, tval: 0});
    pushed++;
  endtask

  task automatic chk_quiet(string n);
    chk({n, "_strobes"}, 32'({trap_req, insert_pc, cause_we, epc_we, tval_we, mstatus_trap_we, mstatus_ret_we, busy}), 0);
    chk({n, "_data"}, priv_pc | cause_next | epc_next | tval_next, 0);
  endtask

  // Monitor: every redirect must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (insert_pc) begin
      seen++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit priv_pc=%h required no commit", priv_pc);
      end else begin
        e = q.pop_front();
        chk("commit_kind", 32'({mstatus_ret_we, mstatus_trap_we, cause_we, epc_we, tval_we}), e.ret ? 32'h10 : 32'h0F);
        chk("priv_pc", priv_pc, e.pc);
        if (!e.ret) begin
          chk("cause_next", cause_next, e.cause);
          chk("epc_next", epc_next, e.epc);
          chk("tval_next", tval_next, e.tval);
        end
      end
    end
  end

  initial begin
    step(2);
    chk_quiet("in_reset");
    RST = 0;
    step(1);
    chk_quiet("after_reset");
    // Breakpoint beats lower code 2; flush held two cycles; exception during flush dropped.
    mtvec_base = 32'h200;
    expect_trap(32'h200, 32'h3, 32'h400, 32'hDEAD);
    exc_req = 16'h000C; exc_epc = 32'h400; exc_tval = 32'hDEAD;
    step(1);
    exc_req = 16'h0002;
    chk("t1_flush1", trap_req, 1);
    step(1);
    exc_req = 0;
    chk("t1_flush2", trap_req, 1);
    pipe_clear = 1;
    step(1);
    chk("t1_commit_busy", busy, 1);
    step(1);
    pipe_clear = 0;
    chk("t1_idle", busy, 0);
    // Vectored interrupt: MEI beats MTI.
    pipe_clear = 1; mtvec_base = 32'h8000; mtvec_mode = 1; mstatus_mie = 1;
    intr_pending = 16'h0880; intr_enable = 16'h0880; next_pc = 32'h555;
    expect_trap(32'h802C, 32'h8000000B, 32'h555, 0);
    step(1);
    intr_pending = 0;
    step(3);
    // Vectored target wraps; unnamed sources resolve highest index first.
    mtvec_base = 32'hFFFF_FFF0; intr_pending = 16'h8070; intr_enable = 16'hFFFF; next_pc = 32'h777;
    expect_trap(32'h0000_002C, 32'h8000000F, 32'h777, 0);
    step(1);
    intr_pending = 0;
    step(3);
    // MSI beats MTI and the unnamed lines; direct mode ignores the code.
    mtvec_base = 32'h100; mtvec_mode = 0; intr_pending = 16'h00F8; next_pc = 32'h888;
    expect_trap(32'h100, 32'h80000003, 32'h888, 0);
    step(1);
    intr_pending = 0;
    step(3);
    // Global disable masks interrupts; mret then takes the return path.
    mstatus_mie = 0; intr_pending = 16'h0080; intr_enable = 16'h0080;
    step(2);
    chk("t3_masked_req", trap_req, 0);
    chk("t3_masked_busy", busy, 0);
    mret = 1; mepc_r = 32'h1234;
    expect_ret(32'h1234);
    step(1);
    mret = 0;
    chk("t3_ret_flush", trap_req, 1);
    step(3);
    intr_pending = 0;
    // Exception beats simultaneous mret.
    mtvec_base = 32'h8000;
    exc_req = 16'h0004; mret = 1; exc_epc = 32'h600; exc_tval = 32'h77;
    expect_trap(32'h8000, 32'h2, 32'h600, 32'h77);
    step(1);
    exc_req = 0; mret = 0;
    step(3);
    // Exception beats an enabled interrupt; lowest index without breakpoint.
    mstatus_mie = 1; intr_pending = 16'h0800; intr_enable = 16'h0800;
    exc_req = 16'h0110; exc_epc = 32'h900; exc_tval = 32'h11;
    expect_trap(32'h8000, 32'h4, 32'h900, 32'h11);
    step(1);
    exc_req = 0; intr_pending = 0;
    step(3);
    // Reset in TRAP_FLUSH kills everything immediately; no commit follows.
    pipe_clear = 0; exc_req = 16'h0001; exc_epc = 32'hA00;
    step(1);
    exc_req = 0;
    chk("t5_flush", trap_req, 1);
    RST = 1;
    #1;
    chk_quiet("t5_rst_same_cycle");
    step(1);
    RST = 0;
    #1;
    chk_quiet("t5_after_rst");
    pipe_clear = 1;
    step(4);
    chk("t5_no_commit", seen, pushed);
    // A level interrupt re-traps, but not in the cycle the commit exits.
    mtvec_base = 32'h300; intr_pending = 16'h0080; intr_enable = 16'h0080; next_pc = 32'hB00;
    expect_trap(32'h300, 32'h80000007, 32'hB00, 0);
    expect_trap(32'h300, 32'h80000007, 32'hB00, 0);
    step(3);
    chk("t6_idle_gap", busy, 0);
    step(1);
    chk("t6_reaccept", busy, 1);
    intr_pending = 0;
    step(3);
`ifdef PRIV_NMI_EN
    mtvec_base = 32'h8000; mtvec_mode = 1; mstatus_mie = 0;
    nmi = 1; exc_req = 16'h0004; next_pc = 32'hC00;
    expect_trap(32'h100, 32'h80000000, 32'hC00, 0);
    step(1);
    nmi = 0; exc_req = 0;
    step(3);
`endif
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
    chk("drain", q.size(), 0);
    chk("commit_count", seen, pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
